// File: rtl/phrase_player_if.sv
// Bus bundle for phrase_player: control strobes, phrase ROM lookup and note outputs.
// The master side drives the controls and serves the ROM; phrase_player is the slave.
interface phrase_player_if;
    logic        tick_en;
    logic        start;
    logic        stop;
    logic [3:0]  phrase_sel;
    logic        triplet;
    logic [3:0]  db_addr;
    logic [31:0] db_entry;
    logic [7:0]  length_entry;
    logic [2:0]  n_note;
    logic [3:0]  note_code;
    logic        note_valid;
    logic        note_start;
    logic        busy;
    logic        done;

    modport master (
        output tick_en, start, stop, phrase_sel, triplet,
        output db_entry, length_entry, n_note,
        input  db_addr, note_code, note_valid, note_start, busy, done
    );

    modport slave (
        input  tick_en, start, stop, phrase_sel, triplet,
        input  db_entry, length_entry, n_note,
        output db_addr, note_code, note_valid, note_start, busy, done
    );
endinterface

// File: rtl/phrase_player.sv
// phrase_player: fetches one phrase entry from the phrase ROM and plays its notes
// MSB nibble first, each note lasting a number of tick_en strobes chosen by its length bit.
// Optional feature macro: PHRASE_TRIPLET_EN (triplet timing, every note TRIPLET_TICKS long).
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | ROM addressed, capture entry and first note duration
// PLAY   | a note is sounding, counting tick_en down
// DONE   | one-cycle done pulse after the last note
module phrase_player #(
    parameter int SHORT_TICKS   = 3,
    parameter int LONG_TICKS    = 6,
    parameter int TRIPLET_TICKS = 2,
    parameter int CNT_W         = 4
) (
    input  logic            clk,
    input  logic            rst,
    phrase_player_if.slave  bus
);
    localparam logic [CNT_W-1:0] C_SHORT = CNT_W'(SHORT_TICKS);
    localparam logic [CNT_W-1:0] C_LONG  = CNT_W'(LONG_TICKS);
    localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);
    localparam logic [3:0]       C_REST  = 4'h7;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_DONE} state_t;

    state_t           r_state;
    logic [3:0]       r_db_addr;
    logic [31:0]      r_entry;
    logic [7:0]       r_len;
    logic [2:0]       r_n_note;
    logic [2:0]       r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_note_code;
    logic             r_note_valid;
    logic             r_note_start;
    logic             r_busy;
    logic             r_done;

    logic [2:0]       w_next_ptr;
    logic [3:0]       w_next_code;
    logic             w_next_len_bit;
    logic [CNT_W-1:0] w_dur0;
    logic [CNT_W-1:0] w_next_dur;

`ifdef PHRASE_TRIPLET_EN
    localparam logic [CNT_W-1:0] C_TRIP = CNT_W'(TRIPLET_TICKS);
    logic r_triplet;

    // Triplet request is latched with the entry and holds for the whole phrase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_triplet <= 1'b0;
        else if (r_state == S_LOAD && !bus.stop)
            r_triplet <= bus.triplet;
    end

    // Note durations, triplet mode overriding the length mask.
    always_comb begin
        w_dur0     = bus.triplet ? C_TRIP : (bus.length_entry[7] ? C_LONG : C_SHORT);
        w_next_dur = r_triplet   ? C_TRIP : (w_next_len_bit     ? C_LONG : C_SHORT);
    end
`else
    logic w_unused_triplet;
    assign w_unused_triplet = bus.triplet;

    // Note durations straight from the length mask.
    always_comb begin
        w_dur0     = bus.length_entry[7] ? C_LONG : C_SHORT;
        w_next_dur = w_next_len_bit      ? C_LONG : C_SHORT;
    end
`endif

    // Lookup of the note that follows the current one.
    always_comb begin
        w_next_ptr     = r_ptr + 3'd1;
        w_next_code    = r_entry[(5'd28 - {w_next_ptr, 2'b00}) +: 4];
        w_next_len_bit = r_len[3'd7 - w_next_ptr];
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_db_addr    <= 4'd0;
            r_entry      <= 32'd0;
            r_len        <= 8'd0;
            r_n_note     <= 3'd0;
            r_ptr        <= 3'd0;
            r_cnt        <= '0;
            r_note_code  <= C_REST;
            r_note_valid <= 1'b0;
            r_note_start <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else if (bus.stop) begin
            r_state      <= S_IDLE;
            r_note_code  <= C_REST;
            r_note_valid <= 1'b0;
            r_note_start <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_note_start <= 1'b0;
                    r_done       <= 1'b0;
                    if (bus.start) begin
                        r_db_addr <= bus.phrase_sel;
                        r_busy    <= 1'b1;
                        r_state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_entry      <= bus.db_entry;
                    r_len        <= bus.length_entry;
                    r_n_note     <= bus.n_note;
                    r_ptr        <= 3'd0;
                    r_cnt        <= w_dur0;
                    r_note_code  <= bus.db_entry[31:28];
                    r_note_valid <= 1'b1;
                    r_note_start <= 1'b1;
                    r_state      <= S_PLAY;
                end
                S_PLAY: begin
                    r_note_start <= 1'b0;
                    if (bus.tick_en) begin
                        if (r_cnt > C_ONE) begin
                            r_cnt <= r_cnt - C_ONE;
                        end else if (r_ptr != r_n_note) begin
                            r_ptr        <= w_next_ptr;
                            r_cnt        <= w_next_dur;
                            r_note_code  <= w_next_code;
                            r_note_start <= 1'b1;
                        end else begin
                            r_note_code  <= C_REST;
                            r_note_valid <= 1'b0;
                            r_done       <= 1'b1;
                            r_state      <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.db_addr    = r_db_addr;
    assign bus.note_code  = r_note_code;
    assign bus.note_valid = r_note_valid;
    assign bus.note_start = r_note_start;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
endmodule

// File: tb/tb_phrase_player.sv
// Scoreboard bench for phrase_player: a ROM model, a note-list reference model,
// randomized phrases with disturbances, plus stop and mid-phrase reset scenarios.
module tb_phrase_player;
`ifdef PHRASE_TRIPLET_EN
    localparam bit TRIP_BUILD = 1'b1;
`else
    localparam bit TRIP_BUILD = 1'b0;
`endif

    typedef struct {
        logic [3:0] code;
        int         ticks;
        bit         is_done;
    } exp_t;

    logic clk;
    logic rst;
    phrase_player_if bus();

    phrase_player #(.SHORT_TICKS(3), .LONG_TICKS(6), .TRIPLET_TICKS(2), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] rom_e  [16];
    logic [7:0]  rom_l  [16];
    logic [2:0]  rom_n  [16];
    logic [31:0] base_e [16];
    logic [7:0]  base_l [16];
    logic [2:0]  base_n [16];

    exp_t sb[$];
    exp_t cur_exp;
    bit   cur_active = 0;
    int   cur_ticks  = 0;
    int   notes_started = 0;
    bit   tick_force = 0;
    int   vectors = 0;
    int   miscompares = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        bus.db_entry     = rom_e[bus.db_addr];
        bus.length_entry = rom_l[bus.db_addr];
        bus.n_note       = rom_n[bus.db_addr];
    end

    initial begin
        bus.tick_en = 0;
        forever begin
            @(posedge clk);
            #1;
            bus.tick_en = tick_force | ($urandom_range(0, 2) == 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic report_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Reference model: the note list a phrase should produce, from the ROM contents at start.
    task automatic push_expected(input logic [3:0] sel, input bit trip);
        exp_t e;
        for (int i = 0; i <= int'(rom_n[sel]); i++) begin
            e.code    = rom_e[sel][31 - 4 * i -: 4];
            e.ticks   = (TRIP_BUILD && trip) ? 2 : (rom_l[sel][7 - i] ? 6 : 3);
            e.is_done = 0;
            sb.push_back(e);
        end
        e.code = 4'h7; e.ticks = 0; e.is_done = 1;
        sb.push_back(e);
    endtask

    // Monitor: pops expected notes on note_start and checks codes, tick counts and done.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.note_start) begin
                    if (cur_active) check("note_ticks", cur_ticks, cur_exp.ticks);
                    if (sb.size() == 0 || sb[0].is_done) begin
                        report_fail("unexpected_note_start");
                        cur_active = 0;
                    end else begin
                        cur_exp    = sb.pop_front();
                        cur_active = 1;
                        cur_ticks  = 0;
                        notes_started++;
                        check("note_code_start", bus.note_code, cur_exp.code);
                        check("note_valid_start", bus.note_valid, 1);
                    end
                end else if (cur_active && bus.note_valid) begin
                    check("note_code_hold", bus.note_code, cur_exp.code);
                end
                if (cur_active && bus.note_valid && bus.tick_en) cur_ticks++;
                if (bus.done) begin
                    if (cur_active) check("note_ticks_last", cur_ticks, cur_exp.ticks);
                    cur_active = 0;
                    if (sb.size() > 0 && sb[0].is_done) begin
                        void'(sb.pop_front());
                        check("done_code", bus.note_code, 4'h7);
                        check("done_valid", bus.note_valid, 0);
                    end else begin
                        report_fail("unexpected_done");
                    end
                end
                if (!bus.busy) check("idle_note_valid", bus.note_valid, 0);
            end
        end
    end

    task automatic run_phrase(input logic [3:0] sel, input bit trip, input bit disturb);
        int n;
        int idx;
        push_expected(sel, trip);
        bus.phrase_sel = sel;
        bus.triplet    = trip;
        bus.start      = 1;
        @(posedge clk); #1;
        bus.start = 0;
        check("busy_after_start", bus.busy, 1);
        check("db_addr_load", bus.db_addr, sel);
        n = 0;
        while (bus.busy && n < 3000) begin
            if (disturb) begin
                if ($urandom_range(0, 7) == 0) begin
                    bus.phrase_sel = 4'($urandom);
                    bus.start      = 1;
                end else begin
                    bus.start = 0;
                end
                if (n >= 1 && $urandom_range(0, 3) == 0) begin
                    idx = $urandom_range(0, 15);
                    rom_e[idx]  = $urandom;
                    rom_l[idx]  = 8'($urandom);
                    rom_n[idx]  = 3'($urandom);
                    bus.triplet = 1'($urandom);
                end
            end
            @(posedge clk); #1;
            n++;
            check("db_addr_hold", bus.db_addr, sel);
        end
        bus.start = 0;
        rom_e = base_e;
        rom_l = base_l;
        rom_n = base_n;
        if (n >= 3000) report_fail("phrase_timeout");
        check("scoreboard_drained", sb.size(), 0);
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int base;
        for (int i = 0; i < 16; i++) begin
            base_e[i] = $urandom;
            base_l[i] = 8'($urandom);
            base_n[i] = 3'($urandom);
        end
        base_e[0] = 32'h1127_2020; base_l[0] = 8'h80; base_n[0] = 3'd6;
        base_e[1] = 32'h3456_0123; base_l[1] = 8'h5A; base_n[1] = 3'd7;
        base_e[3] = 32'h1717_7777; base_l[3] = 8'hF0; base_n[3] = 3'd3;
        base_e[7] = 32'h5463_2400; base_l[7] = 8'h3C; base_n[7] = 3'd5;
        rom_e = base_e;
        rom_l = base_l;
        rom_n = base_n;

        rst = 1;
        bus.start = 0;
        bus.stop = 0;
        bus.phrase_sel = 0;
        bus.triplet = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_db_addr", bus.db_addr, 0);
        check("rst_note_code", bus.note_code, 4'h7);
        check("rst_note_valid", bus.note_valid, 0);
        check("rst_note_start", bus.note_start, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        #2 rst = 0;
        @(posedge clk); #1;

        run_phrase(4'd0, 1'b0, 1'b0);
        run_phrase(4'd3, 1'b0, 1'b0);
        run_phrase(4'd7, 1'b1, 1'b0);
        run_phrase(4'd0, 1'b0, 1'b1);
        for (int k = 0; k < 25; k++)
            run_phrase(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b1);

        // Stop at note 3 of phrase 1, with a competing start in the same cycle.
        base = notes_started;
        push_expected(4'd1, 1'b0);
        bus.phrase_sel = 4'd1; bus.triplet = 0; bus.start = 1;
        @(posedge clk); #1;
        bus.start = 0;
        n = 0;
        while (notes_started < base + 4 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 2000) report_fail("stop_wait_timeout");
        bus.stop = 1;
        bus.start = 1;
        bus.phrase_sel = 4'd0;
        sb.delete();
        cur_active = 0;
        @(posedge clk); #1;
        bus.stop = 0;
        bus.start = 0;
        check("stop_busy", bus.busy, 0);
        check("stop_note_valid", bus.note_valid, 0);
        check("stop_note_code", bus.note_code, 4'h7);
        check("stop_db_addr", bus.db_addr, 4'd1);
        repeat (30) begin
            @(posedge clk); #1;
            check("stop_quiet", {bus.done, bus.busy, bus.note_start}, 0);
        end
        run_phrase(4'd1, 1'b0, 1'b0);

        // Async reset in the middle of a note.
        base = notes_started;
        push_expected(4'd0, 1'b0);
        bus.phrase_sel = 4'd0; bus.start = 1;
        @(posedge clk); #1;
        bus.start = 0;
        n = 0;
        while (notes_started < base + 2 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 2000) report_fail("reset_wait_timeout");
        @(negedge clk); #2;
        rst = 1;
        #1;
        sb.delete();
        cur_active = 0;
        check("arst_db_addr", bus.db_addr, 0);
        check("arst_note_code", bus.note_code, 4'h7);
        check("arst_note_valid", bus.note_valid, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_done_start", {bus.done, bus.note_start}, 0);
        repeat (2) @(posedge clk);
        #3 rst = 0;
        tick_force = 1;
        repeat (20) begin
            @(posedge clk); #1;
            check("post_reset_quiet", {bus.busy, bus.note_valid, bus.note_start, bus.done}, 0);
        end
        tick_force = 0;
        run_phrase(4'd3, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
